// File: rtl/mr_wb_ram.sv
// Pipelined Wishbone RAM: 2-entry in-order request FIFO, fixed LATENCY response, byte-lane writes.
// Optional MR_WB_RAM_ERR_EN: addresses >= DEPTH_WORDS get err_o instead of wrapping.
module mr_wb_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int XLEN        = 32,
  parameter int XLEN_GRAN   = $clog2(XLEN / 8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic                      we_i,
  input  logic [XLEN-XLEN_GRAN-1:0] addr_i,
  input  logic [XLEN/8-1:0]         sel_i,
  input  logic [XLEN-1:0]           dat_i,
  output logic                      ack_o,
  output logic                      err_o,
  output logic                      stall_o,
  output logic [XLEN-1:0]           dat_o
);

  localparam int AIW = XLEN - XLEN_GRAN;
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int NB  = XLEN / 8;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [XLEN-1:0] r_mem [0:DEPTH_WORDS-1];

  logic            r_fifo_we   [0:1];
  logic [AIW-1:0]  r_fifo_addr [0:1];
  logic [NB-1:0]   r_fifo_sel  [0:1];
  logic [XLEN-1:0] r_fifo_dat  [0:1];

  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;
  logic [3:0]      r_wait;
  logic            r_stall;
  logic            r_ack;
  logic [XLEN-1:0] r_dat;

  logic            w_accept;
  logic            w_empty;
  logic            w_head_valid;
  logic            w_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_mem_wr;
  logic            w_h_we;
  logic [AIW-1:0]  w_h_addr;
  logic [NB-1:0]   w_h_sel;
  logic [XLEN-1:0] w_h_dat;
  logic [AW-1:0]   w_h_idx;
  logic            w_h_oob;

  logic            w_rd_ptr_next;
  logic            w_wr_ptr_next;
  logic [1:0]      w_count_next;
  logic [3:0]      w_wait_next;

  assign w_accept     = cyc_i & stb_i & ~r_stall & ~rst;
  assign w_empty      = (r_count == 2'd0);
  assign w_head_valid = ~w_empty | w_accept;

  // With an empty FIFO the incoming request is the head, so LATENCY=1 answers it at its own accept edge.
  assign w_h_we   = w_empty ? we_i   : r_fifo_we[r_rd_ptr];
  assign w_h_addr = w_empty ? addr_i : r_fifo_addr[r_rd_ptr];
  assign w_h_sel  = w_empty ? sel_i  : r_fifo_sel[r_rd_ptr];
  assign w_h_dat  = w_empty ? dat_i  : r_fifo_dat[r_rd_ptr];
  assign w_h_idx  = w_h_addr[AW-1:0];

`ifdef MR_WB_RAM_ERR_EN
  localparam logic [AIW-1:0] DEPTH_A = AIW'(DEPTH_WORDS);
  assign w_h_oob = (w_h_addr >= DEPTH_A);
`else
  logic w_unused_addr;
  assign w_h_oob       = 1'b0;
  assign w_unused_addr = ^w_h_addr[AIW-1:AW];
`endif

  assign w_fire   = cyc_i & ~rst & w_head_valid & (r_wait == LAT_M1);
  assign w_push   = w_accept & ~(w_empty & w_fire);
  assign w_pop    = w_fire & ~w_empty;
  assign w_mem_wr = w_fire & w_h_we & ~w_h_oob;

  always_comb begin
    w_rd_ptr_next = r_rd_ptr;
    w_wr_ptr_next = r_wr_ptr;
    w_count_next  = r_count;
    w_wait_next   = 4'd0;
    if (!cyc_i) begin
      // Bus cycle abort: drop everything queued.
      w_rd_ptr_next = 1'b0;
      w_wr_ptr_next = 1'b0;
      w_count_next  = 2'd0;
    end else begin
      if (w_push) w_wr_ptr_next = ~r_wr_ptr;
      if (w_pop)  w_rd_ptr_next = ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + 2'd1;
        2'b01:   w_count_next = r_count - 2'd1;
        default: w_count_next = r_count;
      endcase
      if (w_head_valid && !w_fire) w_wait_next = r_wait + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_wait   <= 4'd0;
      r_stall  <= 1'b0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_count  <= w_count_next;
      r_wait   <= w_wait_next;
      r_stall  <= (w_count_next == 2'd2);
      r_ack    <= w_fire & ~w_h_oob;
      if (w_fire && !w_h_we && !w_h_oob) r_dat <= r_mem[w_h_idx];
    end
  end

`ifdef MR_WB_RAM_ERR_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_fire & w_h_oob;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_we[r_wr_ptr]   <= we_i;
      r_fifo_addr[r_wr_ptr] <= addr_i;
      r_fifo_sel[r_wr_ptr]  <= sel_i;
      r_fifo_dat[r_wr_ptr]  <= dat_i;
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      for (int k = 0; k < NB; k++) begin
        if (w_h_sel[k]) r_mem[w_h_idx][k*8 +: 8] <= w_h_dat[k*8 +: 8];
      end
    end
  end

  assign ack_o   = r_ack;
  assign stall_o = r_stall;
  assign dat_o   = r_dat;

endmodule
